multiplicador_algoritmico: RTL and testbench

- Sequential shift-add multiplier-accumulator; the inverse of the algorithmic divider.
- Rebuilds the dividend from the divider's outputs: Num = Coc*Den + Res, in signed two's complement.
- Uses the same Start/Done handshake as the divider, so it can sit directly after it in a datapath, or in a bench as a round-trip checker.

---
 rtl/divisor_pkg.sv | 27 ++
 rtl/abs_val.sv | 14 +
 rtl/multiplicador_algoritmico.sv | 134 +++++++++++++
 tb/tb_multiplicador_algoritmico.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the algorithmic divider / multiplier pair.
package divisor_pkg;

  typedef enum logic [1:0] {IDLE, OP, FIX, FIN} mult_state_t;

  localparam int unsigned TAMANYO_DEF = 32;

  // Widest slice ovf_check accepts; supports operands up to 128 bits.
  localparam int unsigned OVF_W = 130;

  // The low n bits of hi are the bits that must all equal the result sign;
  // returns 1 when they are mixed.
  function automatic logic ovf_check(input logic [OVF_W-1:0] hi, input int unsigned n);
    logic any_one;
    logic all_one;
    any_one = 1'b0;
    all_one = 1'b1;
    for (int unsigned i = 0; i < OVF_W; i++) begin
      if (i < n) begin
        any_one = any_one | hi[i];
        all_one = all_one & hi[i];
      end
    end
    return any_one && !all_one;
  endfunction

endpackage

// File: rtl/abs_val.sv
// Two's-complement magnitude and sign; the most negative value maps to its exact
// unsigned magnitude.
module abs_val #(
  parameter int unsigned tamanyo = 32
) (
  input  logic [tamanyo-1:0] i_val,
  output logic [tamanyo-1:0] o_mag,
  output logic               o_sign
);

  assign o_sign = i_val[tamanyo-1];
  assign o_mag  = o_sign ? -i_val : i_val;

endmodule

// File: rtl/multiplicador_algoritmico.sv
// Shift-add multiplier-accumulator: Num = Coc*Den + Res with divider-style handshake.
// MULT_EARLY_EXIT_EN: leave OP as soon as the remaining multiplier bits are zero.
module multiplicador_algoritmico
  import divisor_pkg::*;
#(
  parameter int unsigned tamanyo = TAMANYO_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic [tamanyo-1:0] Coc,
  input  logic [tamanyo-1:0] Den,
  input  logic [tamanyo-1:0] Res,
  output logic [tamanyo-1:0] Num,
  output logic               Ovf,
  output logic               Ready,
  output logic               Done
);

  localparam int unsigned CW = $clog2(tamanyo);
  localparam logic [CW-1:0] CNT_INIT = CW'(tamanyo - 1);

  mult_state_t            r_state;
  logic [2*tamanyo-1:0]   r_mcand;
  logic [tamanyo-1:0]     r_mplier;
  logic [2*tamanyo-1:0]   r_acc;
  logic [2*tamanyo:0]     r_res;
  logic                   r_neg;
  logic [CW-1:0]          r_cnt;
  logic [tamanyo-1:0]     r_num;
  logic                   r_ovf;
  logic                   r_done;

  logic [tamanyo-1:0]     w_coc_mag;
  logic [tamanyo-1:0]     w_den_mag;
  logic                   w_coc_sign;
  logic                   w_den_sign;
  logic [tamanyo-1:0]     w_mplier_shr;
  logic                   w_op_last;
  logic [2*tamanyo:0]     w_acc_ext;
  logic [2*tamanyo:0]     w_acc_signed;
  logic [2*tamanyo:0]     w_result;
  logic [OVF_W-1:0]       w_hi_ext;
  logic                   w_ovf;

  abs_val #(.tamanyo(tamanyo)) u_abs_coc (
    .i_val  (Coc),
    .o_mag  (w_coc_mag),
    .o_sign (w_coc_sign)
  );

  abs_val #(.tamanyo(tamanyo)) u_abs_den (
    .i_val  (Den),
    .o_mag  (w_den_mag),
    .o_sign (w_den_sign)
  );

  assign w_mplier_shr = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
  assign w_op_last = (r_cnt == '0) || (w_mplier_shr == '0);
`else
  assign w_op_last = (r_cnt == '0);
`endif

  // Negating a zero accumulator yields zero, so there is no negative zero.
  assign w_acc_ext    = {1'b0, r_acc};
  assign w_acc_signed = r_neg ? -w_acc_ext : w_acc_ext;
  assign w_result     = w_acc_signed + r_res;

  always_comb begin
    w_hi_ext = '0;
    w_hi_ext[tamanyo+1:0] = w_result[2*tamanyo:tamanyo-1];
  end

  assign w_ovf = ovf_check(w_hi_ext, tamanyo + 2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_res    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_num    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_mcand  <= {{tamanyo{1'b0}}, w_coc_mag};
            r_mplier <= w_den_mag;
            r_res    <= {{(tamanyo + 1){Res[tamanyo-1]}}, Res};
            r_neg    <= w_coc_sign ^ w_den_sign;
            r_acc    <= '0;
            r_cnt    <= CNT_INIT;
            r_state  <= OP;
          end
        end
        OP: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shr;
          r_cnt    <= r_cnt - CW'(1);
          if (w_op_last) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_num   <= w_result[tamanyo-1:0];
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_state <= FIN;
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Num   = r_num;
  assign Ovf   = r_ovf;
  assign Done  = r_done;
  assign Ready = (r_state == IDLE);

endmodule

// File: tb/tb_multiplicador_algoritmico.sv
// Directed-vector and round-trip bench for multiplicador_algoritmico (tamanyo = 32).
module tb_multiplicador_algoritmico;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Start;
  logic [W-1:0]  Coc;
  logic [W-1:0]  Den;
  logic [W-1:0]  Res;
  logic [W-1:0]  Num;
  logic          Ovf;
  logic          Ready;
  logic          Done;

  int n_checks = 0;
  int n_fail   = 0;

  multiplicador_algoritmico #(.tamanyo(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .Coc   (Coc),
    .Den   (Den),
    .Res   (Res),
    .Num   (Num),
    .Ovf   (Ovf),
    .Ready (Ready),
    .Done  (Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] coc;
    logic [W-1:0] den;
    logic [W-1:0] res;
    logic [W-1:0] num;
    logic         ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Edges after the Start edge until Done is seen (sampled just after the edge).
  function automatic int exp_lat(input logic [W-1:0] den);
`ifdef MULT_EARLY_EXIT_EN
    logic [W-1:0] mag;
    int hb;
    mag = den[W-1] ? -den : den;
    hb = 0;
    for (int i = 0; i < W; i++) if (mag[i]) hb = i;
    return hb + 2;
`else
    return W + 1;
`endif
  endfunction

  // Called just after a posedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] r,
                        output logic [W-1:0] num, output logic ovf, output int lat,
                        output logic rdy_busy, output logic done_after, output logic rdy_after);
    Start = 1'b1; Coc = c; Den = d; Res = r;
    @(posedge CLK); #1;
    Start = 1'b0;
    Coc = $urandom; Den = $urandom; Res = $urandom;
    rdy_busy = Ready;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!Done && lat < 100);
    num = Num;
    ovf = Ovf;
    @(posedge CLK); #1;
    done_after = Done;
    rdy_after  = Ready;
  endtask

  initial begin
    logic [W-1:0] num;
    logic         ovf;
    logic         rb, da, ra;
    int           lat;
    int           pulses;

    vecs[0]  = '{32'd7,        32'd3,        32'd2,        32'd23,       1'b0};
    vecs[1]  = '{-32'sd7,      32'd3,        -32'sd2,      32'hFFFFFFE9, 1'b0};
    vecs[2]  = '{-32'sd7,      -32'sd3,      32'd0,        32'd21,       1'b0};
    vecs[3]  = '{32'h40000000, 32'd4,        32'd0,        32'd0,        1'b1};
    vecs[4]  = '{32'h80000000, 32'd1,        32'd0,        32'h80000000, 1'b0};
    vecs[5]  = '{32'd0,        32'd12345,    -32'sd5,      32'hFFFFFFFB, 1'b0};
    vecs[6]  = '{32'd1234,     32'd0,        32'd77,       32'd77,       1'b0};
    vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b1};
    vecs[8]  = '{32'h80000000, 32'h80000000, 32'd0,        32'd0,        1'b1};
    vecs[9]  = '{32'h7FFFFFFF, 32'd1,        32'd1,        32'h80000000, 1'b1};
    vecs[10] = '{32'h00010000, 32'h00008000, -32'sd1,      32'h7FFFFFFF, 1'b0};
    vecs[11] = '{-32'sd1,      -32'sd1,      -32'sd2,      32'hFFFFFFFF, 1'b0};

    RST = 1'b1; Start = 1'b0; Coc = '0; Den = '0; Res = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_num",   Num,         32'd0);
    check("reset_ovf",   32'(Ovf),    32'd0);
    check("reset_done",  32'(Done),   32'd0);
    check("reset_ready", 32'(Ready),  32'd1);
    RST = 1'b0;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].coc, vecs[i].den, vecs[i].res, num, ovf, lat, rb, da, ra);
      check($sformatf("vec%0d_num", i),   num,       vecs[i].num);
      check($sformatf("vec%0d_ovf", i),   32'(ovf),  32'(vecs[i].ovf));
      check($sformatf("vec%0d_lat", i),   32'(lat),  32'(exp_lat(vecs[i].den)));
      check($sformatf("vec%0d_busy", i),  32'(rb),   32'd0);
      check($sformatf("vec%0d_pulse", i), 32'(da),   32'd0);
      check($sformatf("vec%0d_ready", i), 32'(ra),   32'd1);
    end

    // Start while busy is ignored: one Done, first result kept.
    Start = 1'b1; Coc = 32'd1; Den = 32'h40000003; Res = 32'd2;
    @(posedge CLK); #1;
    Start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 10) begin
        Start = 1'b1; Coc = 32'd100; Den = 32'd100; Res = 32'd0;
      end
      @(posedge CLK); #1;
      if (c == 10) Start = 1'b0;
      if (Done) pulses++;
    end
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_num",    Num,         32'h40000005);
    check("busy_ready",  32'(Ready),  32'd1);

    // Reset in the middle of an operation aborts it.
    Start = 1'b1; Coc = 32'd7; Den = 32'h40000003; Res = 32'd0;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (14) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("abort_num",   Num,        32'd0);
    check("abort_ready", 32'(Ready), 32'd1);
    check("abort_done",  32'(Done),  32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_op(32'd7, 32'd3, 32'd2, num, ovf, lat, rb, da, ra);
    check("post_abort_num", num,       32'd23);
    check("post_abort_lat", 32'(lat),  32'(exp_lat(32'd3)));

    // Round trip: (n / d) * d + (n % d) must rebuild n.
    for (int i = 0; i < 200; i++) begin
      int signed n, d, q, r;
      n = int'($urandom);
      d = int'($urandom) >>> $urandom_range(0, 31);
      if (d == 0) d = 1;
      if (n == 32'sh80000000 && d == -1) d = 3;
      q = n / d;
      r = n % d;
      run_op(q, d, r, num, ovf, lat, rb, da, ra);
      check($sformatf("rt%0d_num", i), num,      n);
      check($sformatf("rt%0d_ovf", i), 32'(ovf), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
